mont_modexp_ctrl: RTL and testbench

- Sequencer that computes Base^Exp mod m by issuing a chain of Montgomery multiplications to one external Montgomery_MMM core (start/done handshake, K_BITS operands, P = A*B*R^-1 mod m, R = 2^K_BITS).
- Algorithm: left-to-right square-and-multiply in the Montgomery domain, with entry and exit conversions.
- Sits between a host (VIO or bus) and the multiplier core; owns the core's operand, modulus and start lines.

---
 rtl/mont_modexp_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mont_modexp_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_modexp_ctrl.sv
// mont_modexp_ctrl
// Sequencer for Base^Exp mod m. It uses left-to-right square-and-multiply in
// the Montgomery domain and drives one external Montgomery multiplier core
// (P = A*B*R^-1 mod m, R = 2^K_BITS) over a start/done handshake.
//
// Ports
//   i_Clk, i_Rst       clock, asynchronous active-high reset
//   i_Start            job request, accepted only in IDLE
//   i_Base, i_Exp      operands (Base < m)
//   i_m, i_R2          odd modulus and precomputed R^2 mod m
//   o_Result, o_Done   result, held from completion until the next accepted start
//   o_Busy             high from accepted start until completion
//   o_Op_Count         multiplications issued for the current or last job
//   o_Mmm_*            operand, modulus and start lines to the core
//   i_Mmm_P, i_Mmm_Done  core result and completion flag
module mont_modexp_ctrl #(
    parameter int K_BITS = 8,
    parameter int E_BITS = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic [K_BITS-1:0] i_Base,
    input  logic [E_BITS-1:0] i_Exp,
    input  logic [K_BITS-1:0] i_m,
    input  logic [K_BITS-1:0] i_R2,
    output logic [K_BITS-1:0] o_Result,
    output logic              o_Done,
    output logic              o_Busy,
    output logic [15:0]       o_Op_Count,
    output logic              o_Mmm_Start,
    output logic [K_BITS-1:0] o_Mmm_A,
    output logic [K_BITS-1:0] o_Mmm_B,
    output logic [K_BITS-1:0] o_Mmm_m,
    input  logic [K_BITS-1:0] i_Mmm_P,
    input  logic              i_Mmm_Done
);

    localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [K_BITS-1:0] ONE = K_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TO_MONT,
        S_INIT_ACC,
        S_SQUARE,
        S_MUL,
        S_BIT_NEXT,
        S_FROM_MONT,
        S_DONE
    } state_t;

    state_t            state;
    logic              issued;   // the start pulse for the current step has been sent
    logic [K_BITS-1:0] base_q;
    logic [E_BITS-1:0] exp_q;
    logic [K_BITS-1:0] r2_q;
    logic [K_BITS-1:0] xm_q;     // Base in the Montgomery domain
    logic [K_BITS-1:0] acc_q;    // running accumulator, Montgomery domain
    logic [IW-1:0]     bit_idx;

    logic [K_BITS-1:0] op_a;
    logic [K_BITS-1:0] op_b;
    logic              step_done;

    // Operand selection for the multiplication owned by the current state.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            S_TO_MONT:   begin op_a = base_q; op_b = r2_q;  end
            S_INIT_ACC:  begin op_a = ONE;    op_b = r2_q;  end
            S_SQUARE:    begin op_a = acc_q;  op_b = acc_q; end
            S_MUL:       begin op_a = acc_q;  op_b = xm_q;  end
            S_FROM_MONT: begin op_a = acc_q;  op_b = ONE;   end
            default:     begin op_a = '0;     op_b = '0;    end
        endcase
    end

    // The core may still show done from the previous step while the start
    // pulse is on the bus. It clears done only when it samples start, so a
    // done is taken only after the pulse has dropped.
    assign step_done = issued && !o_Mmm_Start && i_Mmm_Done;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            issued      <= 1'b0;
            base_q      <= '0;
            exp_q       <= '0;
            r2_q        <= '0;
            xm_q        <= '0;
            acc_q       <= '0;
            bit_idx     <= '0;
            o_Result    <= '0;
            o_Done      <= 1'b0;
            o_Busy      <= 1'b0;
            o_Op_Count  <= '0;
            o_Mmm_Start <= 1'b0;
            o_Mmm_A     <= '0;
            o_Mmm_B     <= '0;
            o_Mmm_m     <= '0;
        end else begin
            o_Mmm_Start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        base_q     <= i_Base;
                        exp_q      <= i_Exp;
                        r2_q       <= i_R2;
                        o_Mmm_m    <= i_m;
                        o_Busy     <= 1'b1;
                        o_Done     <= 1'b0;
                        o_Op_Count <= '0;
                        issued     <= 1'b0;
                        state      <= S_TO_MONT;
                    end
                end

                S_TO_MONT, S_INIT_ACC, S_SQUARE, S_MUL, S_FROM_MONT: begin
                    if (!issued) begin
                        // Issue: operands and start go out together, and
                        // the operands stay put until the result is taken.
                        o_Mmm_A     <= op_a;
                        o_Mmm_B     <= op_b;
                        o_Mmm_Start <= 1'b1;
                        o_Op_Count  <= o_Op_Count + 16'd1;
                        issued      <= 1'b1;
                    end else if (step_done) begin
                        issued <= 1'b0;
                        case (state)
                            S_TO_MONT: begin
                                xm_q  <= i_Mmm_P;
                                state <= S_INIT_ACC;
                            end
                            S_INIT_ACC: begin
                                acc_q   <= i_Mmm_P;      // R mod m, i.e. 1 in the Montgomery domain
                                bit_idx <= IW'(E_BITS - 1);
                                state   <= S_SQUARE;
                            end
                            S_SQUARE: begin
                                acc_q <= i_Mmm_P;
                                state <= exp_q[bit_idx] ? S_MUL : S_BIT_NEXT;
                            end
                            S_MUL: begin
                                acc_q <= i_Mmm_P;
                                state <= S_BIT_NEXT;
                            end
                            default: begin       // S_FROM_MONT
                                o_Result <= i_Mmm_P;
                                o_Done   <= 1'b1;
                                o_Busy   <= 1'b0;
                                state    <= S_DONE;
                            end
                        endcase
                    end
                end

                S_BIT_NEXT: begin
                    if (bit_idx == '0) begin
                        state <= S_FROM_MONT;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                        state   <= S_SQUARE;
                    end
                end

                // Single-cycle DONE: a start seen in this cycle is dropped.
                S_DONE: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl. It uses a behavioural Montgomery core with a
// random done latency, a queue of expected results pushed by the stimulus,
// and a monitor that pops the queue at each completion and checks the
// per-operation handshake.
module tb_mont_modexp_ctrl;

    localparam int K = 8;
    localparam int E = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [K-1:0]  base = '0;
    logic [E-1:0]  expo = '0;
    logic [K-1:0]  m = '0;
    logic [K-1:0]  r2 = '0;
    logic [K-1:0]  result;
    logic          done;
    logic          busy;
    logic [15:0]   op_count;
    logic          mmm_start;
    logic [K-1:0]  mmm_a;
    logic [K-1:0]  mmm_b;
    logic [K-1:0]  mmm_m;
    logic [K-1:0]  mmm_p;
    logic          mmm_done;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [K-1:0] res;
        logic [15:0]  ops;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mont_modexp_ctrl #(.K_BITS(K), .E_BITS(E)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start),
        .i_Base(base), .i_Exp(expo), .i_m(m), .i_R2(r2),
        .o_Result(result), .o_Done(done), .o_Busy(busy), .o_Op_Count(op_count),
        .o_Mmm_Start(mmm_start), .o_Mmm_A(mmm_a), .o_Mmm_B(mmm_b), .o_Mmm_m(mmm_m),
        .i_Mmm_P(mmm_p), .i_Mmm_Done(mmm_done)
    );

    // Reference Montgomery product a*b*2^-K mod mm, using bitwise REDC.
    function automatic logic [K-1:0] mmm(input logic [K-1:0] a, input logic [K-1:0] b,
                                         input logic [K-1:0] mm);
        int t;
        t = int'(a) * int'(b);
        for (int i = 0; i < K; i++) begin
            if (t % 2 == 1) t = t + int'(mm);
            t = t / 2;
        end
        if (t >= int'(mm)) t = t - int'(mm);
        return K'(t);
    endfunction

    // Core model. It samples the start pulse, clears done, and raises done
    // with the product 1..20 cycles later.
    logic [K-1:0] ca, cb, cm;
    int           cnt;
    logic         pend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mmm_done <= 1'b0; mmm_p <= '0; pend <= 1'b0; cnt <= 0;
            ca <= '0; cb <= '0; cm <= '0;
        end else if (mmm_start) begin
            mmm_done <= 1'b0;
            pend     <= 1'b1;
            cnt      <= int'($urandom_range(1, 20));
            ca <= mmm_a; cb <= mmm_b; cm <= mmm_m;
        end else if (pend) begin
            if (cnt <= 1) begin
                mmm_done <= 1'b1;
                mmm_p    <= mmm(ca, cb, cm);
                pend     <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // Monitor: handshake checks per operation, scoreboard check per job.
    initial begin
        logic         prev_done, prev_start, watching, unstable, stray, dbl;
        logic [K-1:0] sa, sbb, sm;
        int           pulses;
        exp_t         e;
        prev_done = 0; prev_start = 0; watching = 0; unstable = 0;
        stray = 0; dbl = 0; pulses = 0; sa = '0; sbb = '0; sm = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 0; prev_start = 0; watching = 0; unstable = 0;
                stray = 0; dbl = 0; pulses = 0;
            end else begin
                if (mmm_start) begin
                    if (prev_start || watching) dbl = 1;
                    if (!busy) stray = 1;
                    pulses++;
                    watching = 1; unstable = 0;
                    sa = mmm_a; sbb = mmm_b; sm = mmm_m;
                end else if (watching) begin
                    if (mmm_a != sa || mmm_b != sbb || mmm_m != sm) unstable = 1;
                    if (mmm_done) begin
                        watching = 0;
                        total++;
                        if (unstable) begin
                            bad++;
                            $display("FAIL op_stable: operands changed during wait (A=%0d B=%0d, issued A=%0d B=%0d)",
                                     mmm_a, mmm_b, sa, sbb);
                        end
                    end
                end
                if (done && !prev_done) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: result=%0d with no job pending", result);
                    end else begin
                        e = sb.pop_front();
                        total++;
                        if (result != e.res) begin
                            bad++;
                            $display("FAIL result: got %0d want %0d", result, e.res);
                        end
                        total++;
                        if (op_count != e.ops) begin
                            bad++;
                            $display("FAIL op_count: got %0d want %0d", op_count, e.ops);
                        end
                        total++;
                        if (pulses != int'(e.ops)) begin
                            bad++;
                            $display("FAIL start_pulses: got %0d want %0d", pulses, e.ops);
                        end
                        total++;
                        if (stray || dbl || busy) begin
                            bad++;
                            $display("FAIL handshake: stray=%0d double=%0d busy=%0d want 0 0 0", stray, dbl, busy);
                        end
                    end
                    pulses = 0; stray = 0; dbl = 0;
                end
                prev_done = done;
                prev_start = mmm_start;
            end
        end
    end

    task automatic run_job(input logic [K-1:0] b, input logic [E-1:0] e, input logic [K-1:0] mm,
                           input logic [K-1:0] rr, input logic [K-1:0] er, input logic [15:0] eo,
                           input bit spam);
        int n;
        @(negedge clk);
        base = b; expo = e; m = mm; r2 = rr; start = 1'b1;
        sb.push_back('{er, eo});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 5000) begin
            // While busy, push conflicting requests. They must be ignored.
            if (spam && (n % 3 == 0) && n < 120) begin
                start = 1'b1; base = 8'd9; expo = 8'd255;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout: no done within %0d cycles", n);
            void'(sb.pop_back());
            rst = 1'b1; @(negedge clk); rst = 1'b0;
        end else begin
            repeat (4) @(negedge clk);
            total++;
            if (!done || result != er) begin
                bad++;
                $display("FAIL done_held: done=%0d result=%0d want 1 %0d", done, result, er);
            end
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        total++;
        if ({result, done, busy, op_count, mmm_start, mmm_a, mmm_b, mmm_m} != '0) begin
            bad++;
            $display("FAIL reset_state: outputs=%h want 0",
                     {result, done, busy, op_count, mmm_start, mmm_a, mmm_b, mmm_m});
        end
        rst = 1'b0;

        // m=13, R=256, R mod 13 = 9, R2 = 81 mod 13 = 3.
        run_job(8'd5, 8'd3,   8'd13, 8'd3, 8'd8, 16'd13, 0);  // 125 mod 13 = 8
        run_job(8'd7, 8'd0,   8'd13, 8'd3, 8'd1, 16'd11, 0);  // Exp = 0 gives 1
        run_job(8'd0, 8'd5,   8'd13, 8'd3, 8'd0, 16'd13, 0);  // Base = 0 gives 0
        // 2 has order 12 mod 13, 255 = 21*12 + 3, so 2^255 mod 13 = 2^3 = 8.
        run_job(8'd2, 8'd255, 8'd13, 8'd3, 8'd8, 16'd19, 0);
        run_job(8'd3, 8'd4,   8'd13, 8'd3, 8'd3, 16'd12, 1);  // 81 mod 13 = 3, spam ignored
        run_job(8'd0, 8'd5,   8'd1,  8'd0, 8'd0, 16'd13, 0);  // m = 1 gives 0

        // Reset in the middle of a wait: the job is dropped and outputs clear.
        @(negedge clk);
        base = 8'd5; expo = 8'd3; m = 8'd13; r2 = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mmm_start) && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);   // the core needs at least one more cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({result, done, busy, op_count, mmm_start, mmm_a, mmm_b, mmm_m} != '0) begin
            bad++;
            $display("FAIL mid_reset: outputs=%h want 0",
                     {result, done, busy, op_count, mmm_start, mmm_a, mmm_b, mmm_m});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_job(8'd5, 8'd3, 8'd13, 8'd3, 8'd8, 16'd13, 0);

        repeat (5) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d jobs left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
